// File: rtl/periph_bus_pkg.sv
// Shared definitions for the peripheral bus controller.
//   state_t          : access sequencer state encoding (2 bits)
//   PERIPH_BASE_DEF  : default base of the peripheral window
//   PERIPH_SIZE_DEF  : default window size in bytes
//   LED_ADDR         : LED register address inside the window
//   M_CORE / M_DBG   : master index constants for req/gnt/done vectors
package periph_bus_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [31:0] PERIPH_BASE_DEF = 32'h8000_0000;
  localparam logic [31:0] PERIPH_SIZE_DEF = 32'h0000_1000;
  localparam logic [31:0] LED_ADDR        = 32'h8000_0002;
  localparam int          TIMEOUT_DEF     = 16;

  localparam int M_CORE = 0;
  localparam int M_DBG  = 1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   gclk, grst_n : clock, synchronous active-low reset (pointer -> m0)
//   req[1:0]     : request per master
//   advance      : a grant was taken this cycle; move priority off the winner
//   gnt[1:0]     : one-hot grant (combinational from req and pointer)
module rr_arbiter2
  import periph_bus_pkg::*;
(
  input  logic       gclk,
  input  logic       grst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // 1 = m1 wins a tie, 0 = m0 wins a tie
  logic prio_m1;

  always_comb begin
    gnt = req;
    if (req == 2'b11) gnt = prio_m1 ? 2'b10 : 2'b01;
  end

  // Next tie goes to whoever did not just win.
  always_ff @(posedge gclk) begin
    if (!grst_n)                prio_m1 <= 1'b0;
    else if (advance && |gnt)   prio_m1 <= gnt[M_CORE];
  end

endmodule

// File: rtl/periph_bus_ctrl.sv
// Peripheral bus controller: arbitrates m0 (core LSU) and m1 (debug/loader)
// onto the memory-mapped peripheral bus and sequences each access as
// IDLE -> SETUP -> ACCESS -> RESP (window miss skips ACCESS).
// Optional feature: define PERIPH_TIMEOUT_EN to bound the ACCESS wait to
// TIMEOUT_CYCLES not-ready cycles (completes with o_err=1, o_rdata=0).
// Ports:
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_req/i_we[1:0]         : per-master request / write enable
//   i_addr/i_wdata[63:0]    : {m1, m0} address / write data
//   o_gnt[1:0]              : owner, from grant through RESP
//   o_done[1:0]             : one-cycle completion pulse to owner
//   o_err, o_rdata          : status / read data, valid with o_done
//   o_read_cs, o_write_cs   : peripheral strobes during ACCESS
//   o_address, o_wdata      : latched address / write data to peripherals
//   i_rdata, i_ready        : peripheral read data / completion
module periph_bus_ctrl
  import periph_bus_pkg::*;
#(
  parameter logic [31:0] PERIPH_BASE    = PERIPH_BASE_DEF,
  parameter logic [31:0] PERIPH_SIZE    = PERIPH_SIZE_DEF,
  parameter int          TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_req,
  input  logic [1:0]  i_we,
  input  logic [63:0] i_addr,
  input  logic [63:0] i_wdata,
  output logic [1:0]  o_gnt,
  output logic [1:0]  o_done,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic        o_read_cs,
  output logic        o_write_cs,
  output logic [31:0] o_address,
  output logic [31:0] o_wdata,
  input  logic [31:0] i_rdata,
  input  logic        i_ready
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  state_t      state, state_nxt;
  logic [1:0]  arb_gnt, gnt_q;
  logic        we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        grant, sel, in_win, tmo_hit;

  // The pointer only matters in IDLE, so moving it at grant time is
  // indistinguishable from moving it at RESP, and keeps the arbiter's
  // interface to req/advance.
  assign grant = (state == S_IDLE) && |i_req;
  assign sel   = arb_gnt[M_DBG];

  rr_arbiter2 u_arb (
    .gclk    (i_clk),
    .grst_n  (i_rst_n),
    .req     (i_req),
    .advance (grant),
    .gnt     (arb_gnt)
  );

  // Unsigned wrap-around compare covers both window edges in one test.
  assign in_win = (addr_q - PERIPH_BASE) < PERIPH_SIZE;

`ifdef PERIPH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Cleared everywhere outside ACCESS, so it is zero on ACCESS entry.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n || state != S_ACCESS) tmo_cnt <= '0;
    else if (!i_ready)                 tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Fires on the TIMEOUT_CYCLES-th not-ready cycle; i_ready there wins.
  assign tmo_hit = (state == S_ACCESS) && !i_ready &&
                   (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (|i_req) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = in_win ? S_ACCESS : S_RESP;
      S_ACCESS: if (i_ready || tmo_hit) state_nxt = S_RESP;
      S_RESP:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: if (grant) begin
          gnt_q   <= arb_gnt;
          we_q    <= i_we[sel];
          addr_q  <= sel ? i_addr[63:32]  : i_addr[31:0];
          wdata_q <= sel ? i_wdata[63:32] : i_wdata[31:0];
          err_q   <= 1'b0;
          rdata_q <= '0;
        end
        S_SETUP:  err_q <= !in_win;
        S_ACCESS: begin
          if (i_ready) begin
            if (!we_q) rdata_q <= i_rdata;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
        end
        S_RESP:   gnt_q <= '0;
        default:  ;
      endcase
    end
  end

  assign o_gnt      = gnt_q;
  assign o_done     = (state == S_RESP) ? gnt_q : 2'b00;
  assign o_err      = (state == S_RESP) && err_q;
  assign o_rdata    = (state == S_RESP) ? rdata_q : '0;
  assign o_read_cs  = (state == S_ACCESS) && !we_q;
  assign o_write_cs = (state == S_ACCESS) && we_q;
  assign o_address  = addr_q;
  assign o_wdata    = wdata_q;

endmodule
